rvfi_retire_buffer: RTL and testbench

Parametrised RVFI trace collector for multi-issue cores. Accepts up to NRET retirements per cycle, decodes register/memory fields, stamps each with a monotonically increasing `rvfi_order`, and buffers the records in a DEPTH-entry FIFO. The FIFO drains one record per cycle onto a single-channel RVFI port with a valid/ready handshake. It sits between the core's retire stage and the formal checker or trace sink.

---
 rtl/rvfi_retire_buffer_if.sv | 46 ++++
 rtl/rvfi_retire_buffer.sv | 197 +++++++++++++++++++
 tb/tb_rvfi_retire_buffer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rvfi_retire_buffer_if.sv
// Single-channel RVFI trace port: one retired-instruction record per valid/ready transfer.
// The buffer drives the master side; the formal checker or trace sink uses the slave side.
interface rvfi_retire_buffer_if #(
  parameter int XLEN = 32
);
  logic              rvfi_valid;
  logic              rvfi_ready;
  logic [63:0]       rvfi_order;
  logic [31:0]       rvfi_insn;
  logic [4:0]        rvfi_rs1_addr;
  logic [4:0]        rvfi_rs2_addr;
  logic [4:0]        rvfi_rd_addr;
  logic [XLEN-1:0]   rvfi_rs1_rdata;
  logic [XLEN-1:0]   rvfi_rs2_rdata;
  logic [XLEN-1:0]   rvfi_rd_wdata;
  logic [XLEN-1:0]   rvfi_pc_rdata;
  logic [XLEN-1:0]   rvfi_pc_wdata;
  logic [XLEN-1:0]   rvfi_mem_addr;
  logic [XLEN-1:0]   rvfi_mem_rdata;
  logic [XLEN-1:0]   rvfi_mem_wdata;
  logic [XLEN/8-1:0] rvfi_mem_rmask;
  logic [XLEN/8-1:0] rvfi_mem_wmask;
  logic              rvfi_trap;
  logic              rvfi_halt;
  logic              rvfi_intr;
  logic [1:0]        rvfi_mode;
  logic [1:0]        rvfi_ixl;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn,
    output rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
    output rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
    output rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask,
    output rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode, rvfi_ixl,
    input  rvfi_ready
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn,
    input  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
    input  rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata, rvfi_pc_rdata, rvfi_pc_wdata,
    input  rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata, rvfi_mem_rmask, rvfi_mem_wmask,
    input  rvfi_trap, rvfi_halt, rvfi_intr, rvfi_mode, rvfi_ixl,
    output rvfi_ready
  );
endinterface

// File: rtl/rvfi_retire_buffer.sv
// Multi-lane RVFI trace collector: decodes up to NRET retirements per cycle, stamps orders,
// compacts them into a DEPTH-entry FIFO and drains one record per cycle onto the RVFI port.
module rvfi_retire_buffer #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NRET-1:0]            retire,
  input  logic [NRET*32-1:0]         instruction,
  input  logic [NRET*XLEN-1:0]       old_pc,
  input  logic [NRET*XLEN-1:0]       new_pc,
  input  logic [NRET*XLEN-1:0]       rs1_rdata,
  input  logic [NRET*XLEN-1:0]       rs2_rdata,
  input  logic [NRET*XLEN-1:0]       rd_wdata,
  input  logic [NRET-1:0]            mem_req,
  input  logic [NRET-1:0]            mem_we,
  input  logic [NRET*XLEN-1:0]       mem_addr,
  input  logic [NRET*XLEN-1:0]       mem_rdata,
  input  logic [NRET*XLEN-1:0]       mem_wdata,
  input  logic [NRET*XLEN/8-1:0]     mem_be,
  rvfi_retire_buffer_if.master       trace,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int MW = XLEN / 8;
  localparam int KW = $clog2(NRET + 1);

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef struct packed {
    logic [63:0]     order;
    logic [31:0]     insn;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] rs1_rdata;
    logic [XLEN-1:0] rs2_rdata;
    logic [XLEN-1:0] rd_wdata;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_rdata;
    logic [XLEN-1:0] mem_wdata;
    logic [MW-1:0]   mem_rmask;
    logic [MW-1:0]   mem_wmask;
  } rec_t;

  function automatic rec_t decode_lane(
    input logic [31:0]     insn,
    input logic [XLEN-1:0] pc_r,
    input logic [XLEN-1:0] pc_w,
    input logic [XLEN-1:0] rs1_d,
    input logic [XLEN-1:0] rs2_d,
    input logic [XLEN-1:0] rd_d,
    input logic            req,
    input logic            we,
    input logic [XLEN-1:0] addr,
    input logic [XLEN-1:0] rdata,
    input logic [XLEN-1:0] wdata,
    input logic [MW-1:0]   be,
    input logic [XLEN-1:0] be_bits
  );
    rec_t       r;
    logic [6:0] opc;
    r          = '0;
    opc        = insn[6:0];
    r.insn     = insn;
    r.pc_rdata = pc_r;
    r.pc_wdata = pc_w;
    r.rd_addr  = (opc == OP_STORE || opc == OP_BRANCH) ? 5'd0 : insn[11:7];
    r.rs1_addr = (opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL) ? 5'd0 : insn[19:15];
    r.rs2_addr = (opc == OP_OP || opc == OP_STORE || opc == OP_BRANCH) ? insn[24:20] : 5'd0;
    // x0 never carries data, whatever the core reported
    r.rs1_rdata = (r.rs1_addr == 5'd0) ? '0 : rs1_d;
    r.rs2_rdata = (r.rs2_addr == 5'd0) ? '0 : rs2_d;
    r.rd_wdata  = (r.rd_addr  == 5'd0) ? '0 : rd_d;
    if (req) begin
      r.mem_addr = addr;
      if (we) begin
        r.mem_wmask = be;
        r.mem_wdata = wdata & be_bits;
      end else begin
        r.mem_rmask = be;
        r.mem_rdata = rdata & be_bits;
      end
    end
    return r;
  endfunction

  rec_t                 mem [DEPTH];
  rec_t                 lane_rec [NRET];
  logic [KW-1:0]        lane_rank [NRET];
  logic [KW-1:0]        push_count;
  logic [NRET*XLEN-1:0] be_bits;

  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]        level_reg, level_next;
  logic [63:0]          next_order_reg;
  logic                 overflow_reg;
  logic                 push_ok, head_valid, pop;
  rec_t                 head_rec, out_rec;

  // Byte enables widened to a bit mask per lane
  for (genvar gi = 0; gi < NRET * MW; gi++) begin : g_be
    assign be_bits[gi*8 +: 8] = {8{mem_be[gi]}};
  end

  always_comb begin
    push_count = '0;
    for (int i = 0; i < NRET; i++) begin
      lane_rec[i] = decode_lane(instruction[i*32 +: 32], old_pc[i*XLEN +: XLEN],
                                new_pc[i*XLEN +: XLEN], rs1_rdata[i*XLEN +: XLEN],
                                rs2_rdata[i*XLEN +: XLEN], rd_wdata[i*XLEN +: XLEN],
                                mem_req[i], mem_we[i], mem_addr[i*XLEN +: XLEN],
                                mem_rdata[i*XLEN +: XLEN], mem_wdata[i*XLEN +: XLEN],
                                mem_be[i*MW +: MW], be_bits[i*XLEN +: XLEN]);
      lane_rank[i]      = push_count;
      lane_rec[i].order = next_order_reg + 64'(push_count);
      push_count        = push_count + KW'(retire[i]);
    end
  end

  // Admission uses occupancy before this cycle's pop, so a full FIFO drops even while draining
  assign head_valid = (level_reg != '0);
  assign pop        = head_valid && trace.rvfi_ready;
  assign push_ok    = int'(push_count) <= (DEPTH - int'(level_reg));
  assign level_next = level_reg + (push_ok ? LW'(push_count) : LW'(0)) - LW'(pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      next_order_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg     <= wr_ptr_reg + AW'(push_count);
        next_order_reg <= next_order_reg + 64'(push_count);
      end else begin
        overflow_reg <= 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      level_reg <= level_next;
    end
  end

  // Storage needs no reset: the output gate hides stale entries whenever level is 0
  always_ff @(posedge clock) begin
    if (push_ok) begin
      for (int i = 0; i < NRET; i++) begin
        if (retire[i]) begin
          mem[wr_ptr_reg + AW'(lane_rank[i])] <= lane_rec[i];
        end
      end
    end
  end

  assign head_rec = mem[rd_ptr_reg];
  assign out_rec  = head_valid ? head_rec : '0;

  assign trace.rvfi_valid     = head_valid;
  assign trace.rvfi_order     = out_rec.order;
  assign trace.rvfi_insn      = out_rec.insn;
  assign trace.rvfi_rs1_addr  = out_rec.rs1_addr;
  assign trace.rvfi_rs2_addr  = out_rec.rs2_addr;
  assign trace.rvfi_rd_addr   = out_rec.rd_addr;
  assign trace.rvfi_rs1_rdata = out_rec.rs1_rdata;
  assign trace.rvfi_rs2_rdata = out_rec.rs2_rdata;
  assign trace.rvfi_rd_wdata  = out_rec.rd_wdata;
  assign trace.rvfi_pc_rdata  = out_rec.pc_rdata;
  assign trace.rvfi_pc_wdata  = out_rec.pc_wdata;
  assign trace.rvfi_mem_addr  = out_rec.mem_addr;
  assign trace.rvfi_mem_rdata = out_rec.mem_rdata;
  assign trace.rvfi_mem_wdata = out_rec.mem_wdata;
  assign trace.rvfi_mem_rmask = out_rec.mem_rmask;
  assign trace.rvfi_mem_wmask = out_rec.mem_wmask;
  assign trace.rvfi_trap      = 1'b0;
  assign trace.rvfi_halt      = 1'b0;
  assign trace.rvfi_intr      = 1'b0;
  assign trace.rvfi_mode      = 2'b00;
  assign trace.rvfi_ixl       = 2'b00;

  assign level    = level_reg;
  assign overflow = overflow_reg;
endmodule

// File: tb/tb_rvfi_retire_buffer.sv
// Randomised and directed bench for rvfi_retire_buffer; a queue-based model of the trace
// stream supplies every expected record, level and overflow value.
module tb_rvfi_retire_buffer;
  localparam int XLEN  = 32;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [63:0] order;
    logic [31:0] insn;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1d, rs2d, rdd, pcr, pcw, maddr, mrd, mwd;
    logic [3:0]  rm, wm;
  } rec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  retire = '0;
  logic [63:0] instruction = '0;
  logic [63:0] old_pc = '0, new_pc = '0, rs1_rdata = '0, rs2_rdata = '0, rd_wdata = '0;
  logic [1:0]  mem_req = '0, mem_we = '0;
  logic [63:0] mem_addr = '0, mem_rdata = '0, mem_wdata = '0;
  logic [7:0]  mem_be = '0;
  logic [3:0]  level;
  logic        overflow;
  rec_t        obs;

  rvfi_retire_buffer_if #(.XLEN(XLEN)) trace_if ();

  rvfi_retire_buffer #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .retire(retire), .instruction(instruction),
    .old_pc(old_pc), .new_pc(new_pc), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
    .rd_wdata(rd_wdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_be(mem_be), .trace(trace_if),
    .level(level), .overflow(overflow)
  );

  always #5 clock = ~clock;

  assign obs = {trace_if.rvfi_order, trace_if.rvfi_insn, trace_if.rvfi_rs1_addr,
                trace_if.rvfi_rs2_addr, trace_if.rvfi_rd_addr, trace_if.rvfi_rs1_rdata,
                trace_if.rvfi_rs2_rdata, trace_if.rvfi_rd_wdata, trace_if.rvfi_pc_rdata,
                trace_if.rvfi_pc_wdata, trace_if.rvfi_mem_addr, trace_if.rvfi_mem_rdata,
                trace_if.rvfi_mem_wdata, trace_if.rvfi_mem_rmask, trace_if.rvfi_mem_wmask};

  int          checks = 0;
  int          errors = 0;
  rec_t        model_q[$];
  logic [63:0] model_order = '0;
  logic        model_ovf = 1'b0;
  logic [6:0]  ops [9] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                           7'b1101111, 7'b0000011, 7'b0010011, 7'b1100111};

  // Expected record from the architectural rules for one lane's current inputs
  function automatic rec_t ref_record(int i);
    rec_t        r;
    logic [31:0] w;
    logic [6:0]  op;
    w = instruction[i*32 +: 32];
    op = w[6:0];
    r = '0;
    r.insn = w;
    r.pcr  = old_pc[i*32 +: 32];
    r.pcw  = new_pc[i*32 +: 32];
    r.rd   = (op inside {7'b0100011, 7'b1100011}) ? 5'd0 : w[11:7];
    r.rs1  = (op inside {7'b0110111, 7'b0010111, 7'b1101111}) ? 5'd0 : w[19:15];
    r.rs2  = (op inside {7'b0110011, 7'b0100011, 7'b1100011}) ? w[24:20] : 5'd0;
    if (r.rs1 != 0) r.rs1d = rs1_rdata[i*32 +: 32];
    if (r.rs2 != 0) r.rs2d = rs2_rdata[i*32 +: 32];
    if (r.rd != 0)  r.rdd  = rd_wdata[i*32 +: 32];
    if (mem_req[i]) begin
      r.maddr = mem_addr[i*32 +: 32];
      if (mem_we[i]) r.wm = mem_be[i*4 +: 4];
      else           r.rm = mem_be[i*4 +: 4];
      for (int b = 0; b < 4; b++) begin
        if (mem_be[i*4 + b]) begin
          if (mem_we[i]) r.mwd[b*8 +: 8] = mem_wdata[i*32 + b*8 +: 8];
          else           r.mrd[b*8 +: 8] = mem_rdata[i*32 + b*8 +: 8];
        end
      end
    end
    return r;
  endfunction

  // One clock: model the cycle from the inputs in force, then advance DUT and model together
  task automatic tick();
    rec_t incoming[$];
    rec_t r;
    bit   pop;
    int   k;
    pop = (model_q.size() != 0) && trace_if.rvfi_ready;
    k = $countones(retire);
    if (k > DEPTH - model_q.size()) begin
      model_ovf = 1'b1;
    end else begin
      for (int i = 0; i < NRET; i++) begin
        if (retire[i]) begin
          r = ref_record(i);
          r.order = model_order;
          model_order = model_order + 64'd1;
          incoming.push_back(r);
        end
      end
    end
    @(posedge clock);
    #1;
    if (pop) begin
      $display("pop   order=%0d insn=%h", model_q[0].order, model_q[0].insn);
      void'(model_q.pop_front());
    end
    foreach (incoming[j]) begin
      $display("push  order=%0d insn=%h", incoming[j].order, incoming[j].insn);
      model_q.push_back(incoming[j]);
    end
  endtask

  task automatic randomize_lanes();
    logic [31:0] w;
    for (int i = 0; i < NRET; i++) begin
      w = $urandom();
      w[6:0] = ops[$urandom_range(0, 8)];
      if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
      if ($urandom_range(0, 3) == 0) w[11:7] = 5'd0;
      instruction[i*32 +: 32] = w;
      old_pc[i*32 +: 32]    = $urandom();
      new_pc[i*32 +: 32]    = $urandom();
      rs1_rdata[i*32 +: 32] = $urandom();
      rs2_rdata[i*32 +: 32] = $urandom();
      rd_wdata[i*32 +: 32]  = $urandom();
      mem_addr[i*32 +: 32]  = $urandom();
      mem_rdata[i*32 +: 32] = $urandom();
      mem_wdata[i*32 +: 32] = $urandom();
      mem_be[i*4 +: 4]      = 4'($urandom());
      mem_req[i]            = 1'($urandom());
      mem_we[i]             = 1'($urandom());
    end
  endtask

  task automatic do_reset();
    retire = '0;
    trace_if.rvfi_ready = 1'b0;
    reset = 1'b1;
    #3;
    model_q.delete();
    model_order = '0;
    model_ovf = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    trace_if.rvfi_ready = 1'b1;
    #2;
    checks++;
    if (level !== 4'd0 || trace_if.rvfi_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: level=%0d valid=%b ovf=%b required 0/0/0", level, trace_if.rvfi_valid, overflow);
    end
    checks++;
    if (obs !== '0 || {trace_if.rvfi_trap, trace_if.rvfi_halt, trace_if.rvfi_intr, trace_if.rvfi_mode, trace_if.rvfi_ixl} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required all zero", obs);
    end
    do_reset();
  endtask

  task automatic test_add();
    do_reset();
    trace_if.rvfi_ready = 1'b1;
    randomize_lanes();
    instruction[31:0] = 32'h002081B3;
    rs1_rdata[31:0] = 32'd5;
    rs2_rdata[31:0] = 32'd7;
    rd_wdata[31:0] = 32'd12;
    mem_req[0] = 1'b0;
    retire = 2'b01;
    tick();
    retire = 2'b00;
    checks++;
    if (trace_if.rvfi_valid !== 1'b1 || obs.order !== 64'd0 || obs.rd !== 5'd3 || obs.rdd !== 32'd12 ||
        obs.rs1 !== 5'd1 || obs.rs2 !== 5'd2 || obs.rs1d !== 32'd5 || obs.rs2d !== 32'd7) begin
      errors++;
      $display("FAIL add_fields: got valid=%b order=%0d rd=%0d rdd=%0d rs1=%0d rs2=%0d required 1/0/3/12/1/2",
               trace_if.rvfi_valid, obs.order, obs.rd, obs.rdd, obs.rs1, obs.rs2);
    end
    checks++;
    if (obs !== model_q[0]) begin
      errors++;
      $display("FAIL add_record: got %h required %h", obs, model_q[0]);
    end
    tick();
    checks++;
    if (trace_if.rvfi_valid !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL add_drained: valid=%b level=%0d required 0/0", trace_if.rvfi_valid, level);
    end
  endtask

  task automatic test_mem_pair();
    do_reset();
    trace_if.rvfi_ready = 1'b1;
    randomize_lanes();
    instruction = {32'h0000A003, 32'h0020A023};
    mem_req = 2'b11;
    mem_we = 2'b01;
    mem_be = 8'h33;
    mem_wdata = {32'hDEADBEEF, 32'hDEADBEEF};
    rd_wdata[63:32] = 32'h00001234;
    retire = 2'b11;
    tick();
    retire = 2'b00;
    checks++;
    if (obs.order !== 64'd0 || obs.wm !== 4'b0011 || obs.mwd !== 32'h0000BEEF || obs.rd !== 5'd0 || obs.rm !== 4'd0) begin
      errors++;
      $display("FAIL sw_record: order=%0d wmask=%b wdata=%h rd=%0d required 0/0011/0000beef/0", obs.order, obs.wm, obs.mwd, obs.rd);
    end
    tick();
    checks++;
    if (obs.order !== 64'd1 || obs.rd !== 5'd0 || obs.rdd !== 32'd0 || obs.rm !== 4'b0011 || obs.wm !== 4'd0) begin
      errors++;
      $display("FAIL lw_x0_record: order=%0d rd=%0d rdd=%h rmask=%b required 1/0/0/0011", obs.order, obs.rd, obs.rdd, obs.rm);
    end
    checks++;
    if (obs !== model_q[0]) begin
      errors++;
      $display("FAIL lw_x0_model: got %h required %h", obs, model_q[0]);
    end
  endtask

  task automatic test_lane1_only();
    do_reset();
    trace_if.rvfi_ready = 1'b1;
    randomize_lanes();
    retire = 2'b10;
    tick();
    retire = 2'b00;
    checks++;
    if (level !== 4'd1 || obs.order !== 64'd0 || obs.insn !== instruction[63:32] || obs !== model_q[0]) begin
      errors++;
      $display("FAIL lane1_only: level=%0d got %h required %h", level, obs, model_q[0]);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      randomize_lanes();
      retire = 2'b11;
      tick();
    end
    checks++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: level=%0d ovf=%b required 8/0", level, overflow);
    end
    randomize_lanes();
    retire = 2'b01;
    tick();
    checks++;
    if (level !== 4'd8 || overflow !== 1'b1 || obs.order !== 64'd0) begin
      errors++;
      $display("FAIL overflow_drop: level=%0d ovf=%b order=%0d required 8/1/0", level, overflow, obs.order);
    end
    // Full with a pop in the same cycle: the retire is still refused
    trace_if.rvfi_ready = 1'b1;
    randomize_lanes();
    tick();
    retire = 2'b00;
    checks++;
    if (level !== 4'(model_q.size()) || level !== 4'd7 || obs !== model_q[0]) begin
      errors++;
      $display("FAIL full_pop: level=%0d required %0d got %h", level, model_q.size(), obs);
    end
    while (model_q.size() != 0) begin
      tick();
      checks++;
      if (level !== 4'(model_q.size()) || (model_q.size() != 0 && obs !== model_q[0])) begin
        errors++;
        $display("FAIL overflow_drain: level=%0d required %0d got %h", level, model_q.size(), obs);
      end
    end
    randomize_lanes();
    retire = 2'b01;
    tick();
    retire = 2'b00;
    checks++;
    if (obs.order !== 64'd8 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL order_after_drop: order=%0d ovf=%b required 8/1", obs.order, overflow);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] prev;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      randomize_lanes();
      retire = (c == 3) ? 2'b01 : 2'b11;
      tick();
    end
    checks++;
    if (level !== 4'd7 || obs.order !== 64'd0) begin
      errors++;
      $display("FAIL wrap_fill: level=%0d order=%0d required 7/0", level, obs.order);
    end
    prev = obs.order;
    trace_if.rvfi_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      randomize_lanes();
      retire = 2'b01;
      tick();
      checks++;
      if (level !== 4'd7 || obs.order !== prev + 64'd1 || obs !== model_q[0]) begin
        errors++;
        $display("FAIL wrap_step%0d: level=%0d order=%0d required 7/%0d", c, level, obs.order, prev + 64'd1);
      end
      prev = prev + 64'd1;
    end
    retire = 2'b00;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      randomize_lanes();
      retire = 2'($urandom());
      trace_if.rvfi_ready = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (level !== 4'(model_q.size()) || overflow !== model_ovf ||
          trace_if.rvfi_valid !== (model_q.size() != 0) ||
          (model_q.size() != 0 && obs !== model_q[0])) begin
        errors++;
        $display("FAIL random_c%0d: level=%0d/%0d ovf=%b/%b got %h required %h", c, level, model_q.size(),
                 overflow, model_ovf, obs, (model_q.size() != 0) ? model_q[0] : rec_t'('0));
      end
    end
    retire = 2'b00;
  endtask

  task automatic test_reset_midstream();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      randomize_lanes();
      retire = (c == 2) ? 2'b01 : 2'b11;
      tick();
    end
    retire = 2'b00;
    checks++;
    if (level !== 4'd5) begin
      errors++;
      $display("FAIL mid_fill: level=%0d required 5", level);
    end
    reset = 1'b1;
    #2;
    checks++;
    if (level !== 4'd0 || trace_if.rvfi_valid !== 1'b0 || overflow !== 1'b0 || obs !== '0) begin
      errors++;
      $display("FAIL mid_reset: level=%0d valid=%b ovf=%b required 0/0/0", level, trace_if.rvfi_valid, overflow);
    end
    do_reset();
    trace_if.rvfi_ready = 1'b1;
    randomize_lanes();
    retire = 2'b01;
    tick();
    retire = 2'b00;
    checks++;
    if (trace_if.rvfi_valid !== 1'b1 || obs.order !== 64'd0 || obs !== model_q[0]) begin
      errors++;
      $display("FAIL post_reset_order: valid=%b order=%0d required 1/0", trace_if.rvfi_valid, obs.order);
    end
  endtask

  initial begin
    trace_if.rvfi_ready = 1'b0;
    test_reset();
    test_add();
    test_mem_pair();
    test_lane1_only();
    test_overflow();
    test_wrap();
    test_random();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
